// File: rtl/sh7604_pkg.sv
// Shared SH7604 data-bus types: bus-owner encoding and DMAC burst length.
package SH7604_PKG;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CPU  = 2'd1,
      DMA  = 2'd2
   } DBUS_OWNER_t;

   localparam int DBUS_BURST_BEATS = 4;

   // Beat counter counts down to 0, so a burst loads beats-1.
   localparam logic [1:0] DBUS_BURST_LOAD = 2'(DBUS_BURST_BEATS - 1);

endpackage

// File: rtl/sh7604_dbus_arb.sv
// CPU/DMAC data-bus arbiter in front of the BSC; ownership changes on CE_R, beats complete on CE_F.
// Define SH7604_DBUS_ARB_RR_EN for round-robin between simultaneous requests (default: DMA over CPU).
module sh7604_dbus_arb
   import SH7604_PKG::*;
(
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        CE_R,
   input  logic        CE_F,

   input  logic [31:0] CPU_A,
   input  logic [31:0] CPU_DO,
   input  logic [3:0]  CPU_BA,
   input  logic        CPU_WE,
   input  logic        CPU_REQ,
   output logic [31:0] CPU_DI,
   output logic        CPU_WAIT,

   input  logic [31:0] DMA_A,
   input  logic [31:0] DMA_DO,
   input  logic [3:0]  DMA_BA,
   input  logic        DMA_WE,
   input  logic        DMA_REQ,
   input  logic        DMA_LOCK,
   input  logic        DMA_BURST,
   output logic [31:0] DMA_DI,
   output logic        DMA_WAIT,
   output logic        DMA_ACK,

   output logic [31:0] BUS_A,
   output logic [31:0] BUS_DO,
   output logic [3:0]  BUS_BA,
   output logic        BUS_WE,
   output logic        BUS_REQ,
   output logic        BUS_BURST,
   input  logic [31:0] BUS_DI,
   input  logic        BUS_RDY
);

   DBUS_OWNER_t state_reg, state_next;
   logic [1:0]  beats_reg, beats_next;
   logic        done_reg, done_next;
   logic        stay_reg, stay_next;
   logic        owner_req;
   logic        beat_done;
   logic        dma_first;

`ifdef SH7604_DBUS_ARB_RR_EN
   logic rr_dma_first_reg, rr_dma_first_next;

   // Every grant out of IDLE hands priority to the other master.
   assign rr_dma_first_next = (CE_R && state_reg == IDLE && (CPU_REQ || DMA_REQ))
                              ? ~rr_dma_first_reg : rr_dma_first_reg;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) rr_dma_first_reg <= 1'b1;
      else        rr_dma_first_reg <= rr_dma_first_next;
   end

   assign dma_first = rr_dma_first_reg;
`else
   assign dma_first = 1'b1;
`endif

   assign owner_req = (state_reg == CPU) ? CPU_REQ :
                      (state_reg == DMA) ? DMA_REQ : 1'b0;
   // done_reg blocks a second count of the same beat before CE_R consumes it.
   assign beat_done = CE_F & BUS_RDY & owner_req & ~done_reg;

   assign DMA_ACK  = beat_done & (state_reg == DMA);
   assign CPU_WAIT = CPU_REQ & ~((state_reg == CPU) & BUS_RDY);
   assign DMA_WAIT = DMA_REQ & ~((state_reg == DMA) & BUS_RDY);
   assign CPU_DI   = BUS_DI;
   assign DMA_DI   = BUS_DI;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_reg <= IDLE;
         beats_reg <= 2'd0;
         done_reg  <= 1'b0;
         stay_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         beats_reg <= beats_next;
         done_reg  <= done_next;
         stay_reg  <= stay_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      beats_next = beats_reg;
      done_next  = done_reg;
      stay_next  = stay_reg;

      // Completion is latched on CE_F and acted upon at the following CE_R.
      if (beat_done) begin
         done_next = 1'b1;
         if (state_reg == DMA) begin
            stay_next  = DMA_LOCK | (beats_reg != 2'd0);
            beats_next = (beats_reg != 2'd0) ? beats_reg - 2'd1 : 2'd0;
         end else begin
            stay_next = 1'b0;
         end
      end

      if (CE_R) begin
         done_next = 1'b0;
         stay_next = 1'b0;
         case (state_reg)
            IDLE: begin
               if (DMA_REQ && (!CPU_REQ || dma_first)) begin
                  state_next = DMA;
                  beats_next = DMA_BURST ? DBUS_BURST_LOAD : 2'd0;
               end else if (CPU_REQ) begin
                  state_next = CPU;
                  beats_next = 2'd0;
               end
            end
            CPU: begin
               if (!CPU_REQ || done_reg) begin
                  state_next = IDLE;
                  beats_next = 2'd0;
               end
            end
            DMA: begin
               if (!DMA_REQ || (done_reg && !stay_reg)) begin
                  state_next = IDLE;
                  beats_next = 2'd0;
               end
            end
            default: begin
               state_next = IDLE;
               beats_next = 2'd0;
            end
         endcase
      end
   end

   always_comb begin
      BUS_A     = 32'd0;
      BUS_DO    = 32'd0;
      BUS_BA    = 4'd0;
      BUS_WE    = 1'b0;
      BUS_REQ   = 1'b0;
      BUS_BURST = 1'b0;
      case (state_reg)
         CPU: begin
            BUS_A   = CPU_A;
            BUS_DO  = CPU_DO;
            BUS_BA  = CPU_BA;
            BUS_WE  = CPU_WE;
            BUS_REQ = CPU_REQ;
         end
         DMA: begin
            BUS_A     = DMA_A;
            BUS_DO    = DMA_DO;
            BUS_BA    = DMA_BA;
            BUS_WE    = DMA_WE;
            BUS_REQ   = DMA_REQ;
            BUS_BURST = DMA_BURST;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_sh7604_dbus_arb.sv
// Directed self-checking bench for sh7604_dbus_arb: single beats, priority, burst, lock, abandon, reset, round-robin.
module tb_sh7604_dbus_arb;

   logic        CLK;
   logic        RST_N;
   logic        CE_R, CE_F;
   logic [31:0] CPU_A, CPU_DO, CPU_DI;
   logic [3:0]  CPU_BA;
   logic        CPU_WE, CPU_REQ, CPU_WAIT;
   logic [31:0] DMA_A, DMA_DO, DMA_DI;
   logic [3:0]  DMA_BA;
   logic        DMA_WE, DMA_REQ, DMA_LOCK, DMA_BURST, DMA_WAIT, DMA_ACK;
   logic [31:0] BUS_A, BUS_DO, BUS_DI;
   logic [3:0]  BUS_BA;
   logic        BUS_WE, BUS_REQ, BUS_BURST, BUS_RDY;

   int checks   = 0;
   int failures = 0;
   int ack_cnt  = 0;
   int ack_base = 0;
   logic s_cpu_wait, s_dma_wait, s_ack;
   logic [3:0] exp_dma_grant;

   sh7604_dbus_arb dut (
      .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .CE_F(CE_F),
      .CPU_A(CPU_A), .CPU_DO(CPU_DO), .CPU_BA(CPU_BA), .CPU_WE(CPU_WE), .CPU_REQ(CPU_REQ),
      .CPU_DI(CPU_DI), .CPU_WAIT(CPU_WAIT),
      .DMA_A(DMA_A), .DMA_DO(DMA_DO), .DMA_BA(DMA_BA), .DMA_WE(DMA_WE), .DMA_REQ(DMA_REQ),
      .DMA_LOCK(DMA_LOCK), .DMA_BURST(DMA_BURST), .DMA_DI(DMA_DI), .DMA_WAIT(DMA_WAIT),
      .DMA_ACK(DMA_ACK),
      .BUS_A(BUS_A), .BUS_DO(BUS_DO), .BUS_BA(BUS_BA), .BUS_WE(BUS_WE), .BUS_REQ(BUS_REQ),
      .BUS_BURST(BUS_BURST), .BUS_DI(BUS_DI), .BUS_RDY(BUS_RDY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(negedge CLK) if (DMA_ACK === 1'b1) ack_cnt++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock with the given enables/ready, then everything dropped back to idle levels.
   task automatic cyc(input logic r, input logic f, input logic rdy);
      CE_R = r; CE_F = f; BUS_RDY = rdy;
      @(posedge CLK); #1;
      CE_R = 1'b0; CE_F = 1'b0; BUS_RDY = 1'b0;
   endtask

   // CE_F cycle with BUS_RDY high; combinational outputs sampled before the edge.
   task automatic beat();
      CE_F = 1'b1; BUS_RDY = 1'b1;
      #1;
      s_cpu_wait = CPU_WAIT; s_dma_wait = DMA_WAIT; s_ack = DMA_ACK;
      @(posedge CLK); #1;
      CE_F = 1'b0; BUS_RDY = 1'b0;
   endtask

   initial begin
      RST_N = 1'b0; CE_R = 1'b0; CE_F = 1'b0; BUS_RDY = 1'b0; BUS_DI = 32'd0;
      CPU_A = 32'h0600_0000; CPU_DO = 32'h1111_2222; CPU_BA = 4'hF; CPU_WE = 1'b0; CPU_REQ = 1'b0;
      DMA_A = 32'h0000_1000; DMA_DO = 32'hAAAA_5555; DMA_BA = 4'h3; DMA_WE = 1'b0; DMA_REQ = 1'b0;
      DMA_LOCK = 1'b0; DMA_BURST = 1'b0;
      exp_dma_grant = 4'b1111;
`ifdef SH7604_DBUS_ARB_RR_EN
      exp_dma_grant = 4'b0101;
`endif
      repeat (2) @(posedge CLK); #1;
      chk("rst_bus_req", BUS_REQ, 1'b0);
      chk("rst_bus_burst", BUS_BURST, 1'b0);
      chk("rst_dma_ack", DMA_ACK, 1'b0);
      chk("rst_cpu_wait", CPU_WAIT, 1'b0);
      chk("rst_dma_wait", DMA_WAIT, 1'b0);
      RST_N = 1'b1;
      BUS_DI = 32'hDEAD_BEEF; #1;
      chk("di_cpu", CPU_DI, 32'hDEAD_BEEF);
      chk("di_dma", DMA_DI, 32'hDEAD_BEEF);

      // CPU single access with two wait cycles
      CPU_REQ = 1'b1; #1;
      chk("cpu_wait_ungranted", CPU_WAIT, 1'b1);
      chk("idle_bus_req", BUS_REQ, 1'b0);
      cyc(1, 0, 0);
      chk("cpu_bus_req", BUS_REQ, 1'b1);
      chk("cpu_bus_a", BUS_A, 32'h0600_0000);
      chk("cpu_bus_do", BUS_DO, 32'h1111_2222);
      chk("cpu_bus_ba", BUS_BA, 4'hF);
      cyc(0, 1, 0);
      chk("cpu_wait1", CPU_WAIT, 1'b1);
      cyc(1, 0, 0); cyc(0, 1, 0);
      chk("cpu_wait2", CPU_WAIT, 1'b1);
      cyc(1, 0, 0);
      beat();
      chk("cpu_wait_rdy", s_cpu_wait, 1'b0);
      chk("cpu_no_ack", s_ack, 1'b0);
      cyc(1, 0, 0);
      chk("cpu_back_idle", BUS_REQ, 1'b0);
      chk("cpu_idle_bus_a", BUS_A, 32'd0);
      CPU_REQ = 1'b0;
      cyc(0, 1, 0); cyc(1, 0, 0);
      chk("cpu_wait_noreq", CPU_WAIT, 1'b0);

      // Simultaneous request: DMA first, then CPU
      CPU_REQ = 1'b1; DMA_REQ = 1'b1; DMA_WE = 1'b1;
      cyc(1, 0, 0);
      chk("prio_dma_a", BUS_A, 32'h0000_1000);
      chk("prio_dma_we", BUS_WE, 1'b1);
      chk("prio_cpu_wait", CPU_WAIT, 1'b1);
      chk("prio_dma_wait", DMA_WAIT, 1'b1);
      cyc(0, 1, 0); cyc(1, 0, 0);
      beat();
      chk("prio_dma_ack", s_ack, 1'b1);
      chk("prio_dma_wait_rdy", s_dma_wait, 1'b0);
      chk("prio_cpu_wait_rdy", s_cpu_wait, 1'b1);
      DMA_REQ = 1'b0; DMA_WE = 1'b0;
      cyc(1, 0, 0);
      chk("prio_idle", BUS_REQ, 1'b0);
      chk("prio_cpu_still_wait", CPU_WAIT, 1'b1);
      cyc(0, 1, 0); cyc(1, 0, 0);
      chk("prio_cpu_a", BUS_A, 32'h0600_0000);
      beat();
      CPU_REQ = 1'b0;
      cyc(1, 0, 0);

      // Four-beat burst with CPU pending
      ack_base = ack_cnt;
      CPU_REQ = 1'b1; DMA_REQ = 1'b1; DMA_BURST = 1'b1;
      cyc(1, 0, 0);
      chk("burst_bus_burst", BUS_BURST, 1'b1);
      chk("burst_bus_a", BUS_A, 32'h0000_1000);
      for (int i = 0; i < 4; i++) begin
         beat();
         chk($sformatf("burst_ack%0d", i), s_ack, 1'b1);
         cyc(1, 0, 0);
         if (i < 3) chk($sformatf("burst_hold%0d", i), BUS_A, 32'h0000_1000);
         else       chk("burst_release", BUS_REQ, 1'b0);
      end
      DMA_REQ = 1'b0; DMA_BURST = 1'b0;
      cyc(0, 1, 0); cyc(1, 0, 0);
      chk("burst_cpu_a", BUS_A, 32'h0600_0000);
      chk("burst_cpu_noburst", BUS_BURST, 1'b0);
      chk("burst_ack_count", ack_cnt - ack_base, 4);
      beat();
      CPU_REQ = 1'b0;
      cyc(1, 0, 0);

      // Locked read+write pair with CPU pending
      CPU_REQ = 1'b1; DMA_REQ = 1'b1; DMA_LOCK = 1'b1; DMA_WE = 1'b0;
      cyc(1, 0, 0);
      chk("lock_rd_we", BUS_WE, 1'b0);
      beat();
      chk("lock_rd_ack", s_ack, 1'b1);
      DMA_WE = 1'b1;
      cyc(1, 0, 0);
      chk("lock_hold_a", BUS_A, 32'h0000_1000);
      chk("lock_wr_we", BUS_WE, 1'b1);
      chk("lock_cpu_wait", CPU_WAIT, 1'b1);
      cyc(0, 1, 0); cyc(1, 0, 0);
      chk("lock_hold2_a", BUS_A, 32'h0000_1000);
      DMA_LOCK = 1'b0;
      beat();
      chk("lock_wr_ack", s_ack, 1'b1);
      cyc(1, 0, 0);
      chk("lock_release", BUS_REQ, 1'b0);
      DMA_REQ = 1'b0; DMA_WE = 1'b0;
      cyc(0, 1, 0); cyc(1, 0, 0);
      chk("lock_cpu_a", BUS_A, 32'h0600_0000);
      beat();
      CPU_REQ = 1'b0;
      cyc(1, 0, 0);

      // Abandoned burst, then a single beat must not inherit leftover beats
      DMA_REQ = 1'b1; DMA_BURST = 1'b1;
      cyc(1, 0, 0); beat(); cyc(1, 0, 0);
      chk("abandon_pre", BUS_REQ, 1'b1);
      DMA_REQ = 1'b0;
      cyc(0, 1, 0); cyc(1, 0, 0);
      chk("abandon_idle", BUS_REQ, 1'b0);
      DMA_BURST = 1'b0; DMA_REQ = 1'b1;
      cyc(0, 1, 0); cyc(1, 0, 0);
      chk("single_req", BUS_REQ, 1'b1);
      chk("single_noburst", BUS_BURST, 1'b0);
      beat(); cyc(1, 0, 0);
      chk("single_cnt_clear", BUS_REQ, 1'b0);
      DMA_REQ = 1'b0;
      cyc(0, 1, 0); cyc(1, 0, 0);

      // Reset mid-burst (counter=2)
      DMA_REQ = 1'b1; DMA_BURST = 1'b1;
      cyc(1, 0, 0); beat(); cyc(1, 0, 0);
      chk("mid_burst_req", BUS_REQ, 1'b1);
      ack_base = ack_cnt;
      RST_N = 1'b0; #1;
      chk("rst_mid_bus_req", BUS_REQ, 1'b0);
      chk("rst_mid_bus_burst", BUS_BURST, 1'b0);
      beat();
      chk("rst_mid_ack", s_ack, 1'b0);
      RST_N = 1'b1; #1;
      chk("rst_rel_bus_req", BUS_REQ, 1'b0);
      DMA_REQ = 1'b0; DMA_BURST = 1'b0;
      cyc(1, 0, 0); beat();
      chk("rst_rel_ack", s_ack, 1'b0);
      chk("rst_ack_count", ack_cnt - ack_base, 0);

      // Repeated simultaneous single-beat requests
      for (int i = 0; i < 4; i++) begin
         CPU_REQ = 1'b1; DMA_REQ = 1'b1;
         cyc(1, 0, 0);
         chk($sformatf("arb_grant%0d", i), BUS_A,
             exp_dma_grant[i] ? 32'h0000_1000 : 32'h0600_0000);
         beat();
         CPU_REQ = 1'b0; DMA_REQ = 1'b0;
         cyc(1, 0, 0); cyc(0, 1, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
